// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin arbiter sharing one Gray-to-binary
// decoder among N requesters, feeding a single-entry valid/ready slot.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid            [N]
//   req_gray   packed Gray words, req i at [i*W +: W]  [N*W]
//   req_ready  one-hot grant/accept                    [N]
//   out_valid  output slot holds a decoded result
//   out_bin    decoded binary word                     [W]
//   out_id     requester that produced out_bin         [IDW]
//   out_ready  consumer accepts the output slot
//   xfer_cnt   accepted requests since reset           [CW]
module gray_decode_arbiter #(
   parameter int N   = 4,
   parameter int W   = 4,
   parameter int IDW = 2,
   parameter int CW  = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_gray,
   output logic [N-1:0]   req_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_bin,
   output logic [IDW-1:0] out_id,
   input  logic           out_ready,
   output logic [CW-1:0]  xfer_cnt
);

   logic           r_valid;
   logic [W-1:0]   r_bin;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] r_ptr;
   logic [CW-1:0]  r_cnt;

   logic           w_free;
   logic           w_found;
   logic           w_xfer;
   logic [N-1:0]   w_grant;
   logic [IDW-1:0] w_idx;
   logic [IDW-1:0] w_next;
   logic [W-1:0]   w_gray;
   int             w_pos;

   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int k = W - 2; k >= 0; k--) begin
         b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   // Slot can take a new result if empty or being drained this cycle.
   assign w_free = !r_valid || out_ready;

   // Search starts at r_ptr and wraps; first valid requester wins.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int k = 0; k < N; k++) begin
         w_pos = int'(r_ptr) + k;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end
         if (!w_found && req_valid[w_pos]) begin
            w_found        = 1'b1;
            w_idx          = IDW'(w_pos);
            w_grant[w_pos] = 1'b1;
         end
      end
   end

   // Reset cancels any grant in the same cycle.
   assign req_ready = (w_free && !rst) ? w_grant : '0;
   assign w_xfer    = |req_ready;
   assign w_gray    = req_gray[int'(w_idx)*W +: W];
   assign w_next    = (w_idx == IDW'(N - 1)) ? '0 : w_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_bin   <= '0;
         r_id    <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_bin   <= gray2bin(w_gray);
         r_id    <= w_idx;
         r_ptr   <= w_next;
         r_cnt   <= r_cnt + 1'b1;
      end else if (out_ready) begin
         // Drain keeps the last data, only clears valid.
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_bin   = r_bin;
   assign out_id    = r_id;
   assign xfer_cnt  = r_cnt;

endmodule
